// File: rtl/lsu_pkg.sv
// Shared encodings for the RAM load/store/fetch arbiter: access sizes,
// arbiter FSM states and requester owner codes.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_X = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_ERR  = 2'b10
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    localparam logic [3:0] MASK_ALL = 4'b1111;

endpackage

// File: rtl/lsu_lane_enc.sv
// Byte-lane encoder: lane k holds bits [8k+7:8k], byte offset o lands in lane 3-o,
// so the lowest address (least-significant byte of the value) sits in lane 3.
module lsu_lane_enc
    import lsu_pkg::*;
(
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  mask_o,
    output logic [31:0] wdata_o,
    output logic        misaligned_o
);

    logic [1:0] lane;

    always_comb begin
        mask_o       = 4'b0000;
        wdata_o      = 32'h0;
        misaligned_o = 1'b0;
        lane         = 2'd3 - off_i;
        case (size_e'(size_i))
            SZ_B: begin
                mask_o  = 4'b0001 << lane;
                wdata_o = {24'h0, wdata_i[7:0]} << {lane, 3'b000};
            end
            SZ_H: begin
                if (off_i[0]) begin
                    misaligned_o = 1'b1;
                end else if (off_i[1]) begin
                    mask_o  = 4'b0011;
                    wdata_o = {16'h0, wdata_i[7:0], wdata_i[15:8]};
                end else begin
                    mask_o  = 4'b1100;
                    wdata_o = {wdata_i[7:0], wdata_i[15:8], 16'h0};
                end
            end
            SZ_W: begin
                if (off_i != 2'b00) begin
                    misaligned_o = 1'b1;
                end else begin
                    mask_o  = 4'b1111;
                    wdata_o = {wdata_i[7:0], wdata_i[15:8], wdata_i[23:16], wdata_i[31:24]};
                end
            end
            default: misaligned_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/ram_lsu_arb.sv
// Round-robin arbiter sharing the single-port data RAM between instruction fetch
// and load/store, one access in flight at a time.
module ram_lsu_arb
    import lsu_pkg::*;
#(
    parameter int RAM_AW  = 14,
    parameter int RAM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic              d_sign,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic              d_err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [3:0]        ram_wmask,
    output logic [31:0]       ram_wdata,
    output logic [3:0]        ram_r_mask,
    output logic              ram_r_sign_ext
);

    localparam int LCW = 2;

    state_e         state_q, state_d;
    owner_e         rr_last_q, owner_q;
    logic [LCW-1:0] lat_cnt_q;
    logic [3:0]     r_mask_q;
    logic           r_sext_q;

    logic [3:0]  enc_mask;
    logic [31:0] enc_wdata;
    logic        enc_mis;

    logic        idle, pick_d, any_gnt, gnt_mis, resp;
    logic [31:0] gnt_addr;
    logic        unused_addr;

    lsu_lane_enc u_enc (
        .off_i        (d_addr[1:0]),
        .size_i       (d_size),
        .wdata_i      (d_wdata),
        .mask_o       (enc_mask),
        .wdata_o      (enc_wdata),
        .misaligned_o (enc_mis)
    );

    // D wins a tie only when IF took the previous grant
    assign idle     = (state_q == ST_IDLE);
    assign pick_d   = d_req && (!if_req || (rr_last_q == OWN_IF));
    assign d_gnt    = idle && pick_d;
    assign if_gnt   = idle && if_req && !pick_d;
    assign any_gnt  = if_gnt || d_gnt;
    assign gnt_mis  = d_gnt ? enc_mis : (if_addr[1:0] != 2'b00);
    assign gnt_addr = d_gnt ? d_addr : if_addr;
    assign unused_addr = ^{gnt_addr[31:RAM_AW+2], gnt_addr[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (any_gnt) state_d = gnt_mis ? ST_ERR : ST_BUSY;
            ST_BUSY: if (lat_cnt_q <= LCW'(1)) state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ram_en    = any_gnt && !gnt_mis;
        ram_we    = ram_en && d_gnt && d_we;
        ram_addr  = gnt_addr[RAM_AW+1:2];
        ram_wmask = ram_we ? enc_mask : 4'b0000;
        ram_wdata = ram_we ? enc_wdata : 32'h0;
        resp      = ((state_q == ST_BUSY) && (lat_cnt_q == LCW'(1))) || (state_q == ST_ERR);
        if_rvalid = resp && (owner_q == OWN_IF);
        d_rvalid  = resp && (owner_q == OWN_D);
        if_err    = (state_q == ST_ERR) && (owner_q == OWN_IF);
        d_err     = (state_q == ST_ERR) && (owner_q == OWN_D);
    end

    // Read controls are captured only on a legal grant so they stay put while idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last_q <= OWN_IF;
            owner_q   <= OWN_IF;
            lat_cnt_q <= '0;
            r_mask_q  <= 4'b0000;
            r_sext_q  <= 1'b0;
        end else begin
            if (any_gnt) begin
                rr_last_q <= d_gnt ? OWN_D : OWN_IF;
                owner_q   <= d_gnt ? OWN_D : OWN_IF;
            end
            if (ram_en) begin
                lat_cnt_q <= LCW'(RAM_LAT);
                r_mask_q  <= d_gnt ? enc_mask : MASK_ALL;
                r_sext_q  <= d_gnt && !d_we && d_sign;
            end else if ((state_q == ST_BUSY) && (lat_cnt_q != '0)) begin
                lat_cnt_q <= lat_cnt_q - LCW'(1);
            end
        end
    end

    assign ram_r_mask     = r_mask_q;
    assign ram_r_sign_ext = r_sext_q;

endmodule

// File: tb/tb_ram_lsu_arb.sv
// Bench for ram_lsu_arb: instance 0 uses RAM_LAT=1, instance 1 uses RAM_LAT=3;
// responses are matched against a scoreboard of expected results.
module tb_ram_lsu_arb;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        if_req [2], if_gnt [2], if_rvalid [2], if_err [2];
    logic        d_req [2], d_we [2], d_sign [2], d_gnt [2], d_rvalid [2], d_err [2];
    logic        ram_en [2], ram_we [2], ram_r_sign_ext [2];
    logic [31:0] if_addr [2], d_addr [2], d_wdata [2], ram_wdata [2];
    logic [1:0]  d_size [2];
    logic [13:0] ram_addr [2];
    logic [3:0]  ram_wmask [2], ram_r_mask [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ram_lsu_arb #(.RAM_AW(14), .RAM_LAT(g == 0 ? 1 : 3)) u_dut (
            .clk            (clk),
            .rst            (rst),
            .if_req         (if_req[g]),
            .if_addr        (if_addr[g]),
            .if_gnt         (if_gnt[g]),
            .if_rvalid      (if_rvalid[g]),
            .if_err         (if_err[g]),
            .d_req          (d_req[g]),
            .d_we           (d_we[g]),
            .d_size         (d_size[g]),
            .d_sign         (d_sign[g]),
            .d_addr         (d_addr[g]),
            .d_wdata        (d_wdata[g]),
            .d_gnt          (d_gnt[g]),
            .d_rvalid       (d_rvalid[g]),
            .d_err          (d_err[g]),
            .ram_en         (ram_en[g]),
            .ram_we         (ram_we[g]),
            .ram_addr       (ram_addr[g]),
            .ram_wmask      (ram_wmask[g]),
            .ram_wdata      (ram_wdata[g]),
            .ram_r_mask     (ram_r_mask[g]),
            .ram_r_sign_ext (ram_r_sign_ext[g])
        );
    end

    typedef struct {
        int       g;
        bit       is_d;
        bit       err;
        bit [3:0] rmask;
        bit       sext;
        int       cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        else n_pass++;
    endtask

    // Response monitor: every rvalid must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst) begin
            for (int g = 0; g < 2; g++) begin
                chk("rvalid_excl", 32'(if_rvalid[g] & d_rvalid[g]), 0);
                if (if_rvalid[g] || d_rvalid[g]) begin
                    if (sb.size() == 0) begin
                        chk("rvalid_unexpected", {if_rvalid[g], d_rvalid[g]}, 0);
                    end else begin
                        mon_e = sb.pop_front();
                        chk("rsp_dut", g, mon_e.g);
                        chk("rsp_owner", 32'(d_rvalid[g]), 32'(mon_e.is_d));
                        chk("rsp_err", 32'(d_rvalid[g] ? d_err[g] : if_err[g]), 32'(mon_e.err));
                        chk("rsp_cycle", cyc, mon_e.cyc);
                        if (!mon_e.err) begin
                            chk("rsp_rmask", 32'(ram_r_mask[g]), 32'(mon_e.rmask));
                            chk("rsp_sext", 32'(ram_r_sign_ext[g]), 32'(mon_e.sext));
                        end
                    end
                end
            end
        end
    end

    task automatic op(input int g, input bit is_d, input bit we, input logic [1:0] sz,
                      input bit sgn, input logic [31:0] addr, input logic [31:0] wd,
                      input bit x_err, input logic [3:0] x_wmask, input logic [31:0] x_wdata,
                      input logic [3:0] x_rmask, input bit x_sext);
        exp_t e;
        bit   got = 1'b0;
        int   lat = (g == 0) ? 1 : 3;
        @(posedge clk); #1;
        if (is_d) begin
            d_req[g] = 1'b1; d_we[g] = we; d_size[g] = sz; d_sign[g] = sgn;
            d_addr[g] = addr; d_wdata[g] = wd;
        end else begin
            if_req[g] = 1'b1; if_addr[g] = addr;
        end
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            got = is_d ? d_gnt[g] : if_gnt[g];
        end
        if (!got) begin
            chk("gnt_timeout", 0, 1);
            @(posedge clk); #1;
            d_req[g] = 1'b0; if_req[g] = 1'b0;
            return;
        end
        chk("ram_en", 32'(ram_en[g]), 32'(!x_err));
        if (!x_err) begin
            chk("ram_addr", 32'(ram_addr[g]), 32'(addr[15:2]));
            chk("ram_we", 32'(ram_we[g]), 32'(is_d && we));
            chk("ram_wmask", 32'(ram_wmask[g]), 32'(x_wmask));
            if (is_d && we) chk("ram_wdata", ram_wdata[g], x_wdata);
        end
        e.g = g; e.is_d = is_d; e.err = x_err; e.rmask = x_rmask; e.sext = x_sext;
        e.cyc = cyc + (x_err ? 1 : lat);
        sb.push_back(e);
        @(posedge clk); #1;
        d_req[g] = 1'b0; if_req[g] = 1'b0;
        for (int i = 0; i < 8 && sb.size() != 0; i++) begin
            @(negedge clk);
            if (!x_err) chk("rmask_hold", 32'(ram_r_mask[g]), 32'(x_rmask));
        end
        chk("drain", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit exp_own [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        int got_n;
        int last_gc;
        bit got;
        exp_t e;

        rst = 1'b1;
        for (int g = 0; g < 2; g++) begin
            if_req[g] = 1'b0; if_addr[g] = '0; d_req[g] = 1'b0; d_we[g] = 1'b0;
            d_size[g] = 2'b10; d_sign[g] = 1'b0; d_addr[g] = '0; d_wdata[g] = '0;
        end
        repeat (2) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk("rst_if_rvalid", 32'(if_rvalid[g]), 0);
            chk("rst_d_rvalid", 32'(d_rvalid[g]), 0);
            chk("rst_errs", 32'({if_err[g], d_err[g]}), 0);
            chk("rst_rmask", 32'(ram_r_mask[g]), 0);
            chk("rst_sext", 32'(ram_r_sign_ext[g]), 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        //  g  d  we sz     sg addr          wdata          err wmask    wdata          rmask    sext
        op(0, 1, 0, 2'b10, 0, 32'h100, 32'h0,         0, 4'b0000, 32'h0,         4'b1111, 0);
        op(0, 1, 1, 2'b01, 0, 32'h102, 32'h0000ABCD,  0, 4'b0011, 32'h0000CDAB,  4'b0011, 0);
        op(0, 1, 1, 2'b00, 0, 32'h103, 32'h0000005A,  0, 4'b0001, 32'h0000005A,  4'b0001, 0);
        op(0, 1, 1, 2'b10, 0, 32'h200, 32'h11223344,  0, 4'b1111, 32'h44332211,  4'b1111, 0);
        op(0, 1, 1, 2'b00, 0, 32'h100, 32'hFFFFFFA5,  0, 4'b1000, 32'hA5000000,  4'b1000, 0);
        op(0, 1, 1, 2'b01, 0, 32'h300, 32'h00001234,  0, 4'b1100, 32'h34120000,  4'b1100, 0);
        op(0, 1, 0, 2'b01, 1, 32'h100, 32'h0,         0, 4'b0000, 32'h0,         4'b1100, 1);
        op(0, 1, 0, 2'b10, 0, 32'h101, 32'h0,         1, 4'b0000, 32'h0,         4'b0000, 0);
        op(0, 1, 0, 2'b11, 0, 32'h100, 32'h0,         1, 4'b0000, 32'h0,         4'b0000, 0);
        op(0, 1, 1, 2'b01, 0, 32'h101, 32'hFFFF,      1, 4'b0000, 32'h0,         4'b0000, 0);
        op(0, 0, 0, 2'b00, 0, 32'h300, 32'h0,         0, 4'b0000, 32'h0,         4'b1111, 0);
        op(0, 0, 0, 2'b00, 0, 32'h302, 32'h0,         1, 4'b0000, 32'h0,         4'b0000, 0);

        // Both requesters held from reset: D, IF, D, IF, two cycles apart
        @(posedge clk); #1;
        rst = 1'b1;
        if_req[0] = 1'b1; if_addr[0] = 32'h400;
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_size[0] = 2'b10; d_addr[0] = 32'h104; d_sign[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        got_n = 0;
        last_gc = -1;
        for (int i = 0; i < 30 && got_n < 4; i++) begin
            @(negedge clk);
            chk("gnt_excl", 32'(if_gnt[0] & d_gnt[0]), 0);
            if (if_gnt[0] || d_gnt[0]) begin
                chk("rr_owner", 32'(d_gnt[0]), 32'(exp_own[got_n]));
                if (last_gc >= 0) chk("rr_spacing", cyc - last_gc, 2);
                last_gc = cyc;
                e.g = 0; e.is_d = d_gnt[0]; e.err = 0; e.rmask = 4'b1111; e.sext = 0; e.cyc = cyc + 1;
                sb.push_back(e);
                got_n++;
            end
        end
        chk("rr_count", got_n, 4);
        @(posedge clk); #1;
        if_req[0] = 1'b0; d_req[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("rr_drain", sb.size(), 0);

        // RAM_LAT = 3 signed byte load, then the same access cut short by reset
        op(1, 1, 0, 2'b00, 1, 32'h102, 32'h0, 0, 4'b0000, 32'h0, 4'b0010, 1);
        @(posedge clk); #1;
        d_req[1] = 1'b1; d_we[1] = 1'b0; d_size[1] = 2'b00; d_sign[1] = 1'b1; d_addr[1] = 32'h102;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            got = d_gnt[1];
        end
        chk("rst_mid_gnt", 32'(got), 1);
        @(posedge clk); #1;
        d_req[1] = 1'b0;
        @(negedge clk);
        chk("rst_mid_t1_rmask", 32'(ram_r_mask[1]), 32'h2);
        chk("rst_mid_t1_sext", 32'(ram_r_sign_ext[1]), 1);
        chk("rst_mid_t1_rvalid", 32'(d_rvalid[1]), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_rvalid", 32'(d_rvalid[1]), 0);
        chk("rst_mid_rmask", 32'(ram_r_mask[1]), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_mid_no_rvalid", 32'({if_rvalid[1], d_rvalid[1]}), 0);
        end
        op(1, 0, 0, 2'b00, 0, 32'h500, 32'h0, 0, 4'b0000, 32'h0, 4'b1111, 0);

        repeat (2) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
